logic_reduce_pipe: RTL and testbench

Parametrised, registered successor to the library's 2-input gates. Each accepted beat reduces `NUM_IN` input words of `WIDTH` bits with a selectable bitwise operator: AND, OR, XOR, NAND, NOR or XNOR. Consecutive beats can be folded into a running accumulator until a packet-end marker arrives. The result leaves through a valid/ready output stage, so the block drops into streaming datapaths as a generic combine/merge stage.

---
 rtl/logic_reduce_pkg.sv | 41 ++++
 rtl/logic_reduce_comb.sv | 29 ++
 rtl/logic_reduce_pipe.sv | 144 ++++++++++++++
 tb/tb_logic_reduce_pipe.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_reduce_pkg.sv
// rtl/logic_reduce_pkg.sv - op encodings, FSM states and op helpers for logic_reduce_pipe
package logic_reduce_pkg;

    // in_op encoding; 6 and 7 are reserved
    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5
    } op_e;

    // Base (non-inverting) operators used by the reduction tree and the fold
    localparam logic [1:0] BASE_AND = 2'd0;
    localparam logic [1:0] BASE_OR  = 2'd1;
    localparam logic [1:0] BASE_XOR = 2'd2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    function automatic logic is_reserved(input logic [2:0] op);
        return (op > 3'(OP_XNOR));
    endfunction

    function automatic logic is_inverted(input logic [2:0] op);
        return (op == 3'(OP_NAND)) || (op == 3'(OP_NOR)) || (op == 3'(OP_XNOR));
    endfunction

    // Reserved ops map to AND; their result is forced to zero at the output anyway
    function automatic logic [1:0] base_op(input logic [2:0] op);
        case (op)
            3'(OP_OR), 3'(OP_NOR):   return BASE_OR;
            3'(OP_XOR), 3'(OP_XNOR): return BASE_XOR;
            default:                 return BASE_AND;
        endcase
    endfunction

endpackage

// File: rtl/logic_reduce_comb.sv
// rtl/logic_reduce_comb.sv - combinational bitwise reduction of NUM_IN words with a base op
//
// Ports:
//   in_data  [NUM_IN*WIDTH-1:0] : word k at bits [k*WIDTH +: WIDTH]
//   in_base  [1:0]              : BASE_AND / BASE_OR / BASE_XOR
//   out_data [WIDTH-1:0]        : reduction of all words
module logic_reduce_comb
    import logic_reduce_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [1:0]              in_base,
    output logic [WIDTH-1:0]        out_data
);

    always_comb begin
        out_data = in_data[0 +: WIDTH];
        for (int k = 1; k < NUM_IN; k++) begin
            case (in_base)
                BASE_OR:  out_data = out_data | in_data[k*WIDTH +: WIDTH];
                BASE_XOR: out_data = out_data ^ in_data[k*WIDTH +: WIDTH];
                default:  out_data = out_data & in_data[k*WIDTH +: WIDTH];
            endcase
        end
    end

endmodule

// File: rtl/logic_reduce_pipe.sv
// rtl/logic_reduce_pipe.sv - registered multi-word bitwise reducer with packet fold and valid/ready output
//
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   in_valid/in_ready           : input beat handshake
//   in_data [NUM_IN*WIDTH-1:0]  : input words, word k at [k*WIDTH +: WIDTH]
//   in_op [2:0]                 : op, sampled on the first beat of a packet
//   in_last                     : final beat of packet
//   out_valid/out_ready         : result handshake
//   out_data [WIDTH-1:0]        : packet result
//   out_beats [CNT_W-1:0]       : beats folded into the result, saturating
//   out_err                     : packet used a reserved op
module logic_reduce_pipe
    import logic_reduce_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [2:0]              in_op,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [CNT_W-1:0]        out_beats,
    output logic                    out_err
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q;
    logic [2:0]         op_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept;
    logic               acc_load;
    logic               out_load;
    logic [2:0]         op_eff;
    logic [WIDTH-1:0]   beat_r;
    logic [WIDTH-1:0]   fold_r;
    logic [WIDTH-1:0]   final_r;
    logic [WIDTH-1:0]   result;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   final_cnt;

    // A held result that is being popped this cycle frees the output register
    assign in_ready = rst_n && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // The first beat of a packet uses the live op; later beats use the latched one
    assign op_eff = (state_q == ST_IDLE) ? in_op : op_q;

    logic_reduce_comb #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_beat (
        .in_data  (in_data),
        .in_base  (base_op(op_eff)),
        .out_data (beat_r)
    );

    // Two-word instance folds the current beat into the running accumulator
    logic_reduce_comb #(.WIDTH(WIDTH), .NUM_IN(2)) u_fold (
        .in_data  ({beat_r, acc_q}),
        .in_base  (base_op(op_q)),
        .out_data (fold_r)
    );

    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign final_r   = (state_q == ST_IDLE) ? beat_r : fold_r;
    assign final_cnt = (state_q == ST_IDLE) ? CNT_W'(1) : cnt_inc;

    // Inversion happens only here, so a multi-beat NAND is ~(AND of everything)
    always_comb begin
        if (is_reserved(op_eff)) begin
            result = '0;
        end else if (is_inverted(op_eff)) begin
            result = ~final_r;
        end else begin
            result = final_r;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_load = 1'b0;
        out_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_last) begin
                        out_load = 1'b1;
                    end else begin
                        acc_load = 1'b1;
                        state_d  = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    acc_load = 1'b1;
                    if (in_last) begin
                        out_load = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
            out_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && state_q == ST_IDLE) begin
                op_q <= in_op;
            end
            if (acc_load) begin
                acc_q <= final_r;
                cnt_q <= final_cnt;
            end
            // A push wins over a pop in the same cycle: the new result replaces the old one
            if (out_load) begin
                out_valid <= 1'b1;
                out_data  <= result;
                out_beats <= final_cnt;
                out_err   <= is_reserved(op_eff);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// tb/tb_logic_reduce_pipe.sv - directed table-driven bench for logic_reduce_pipe
module tb_logic_reduce_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [2:0]  in_op;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [7:0]  out_beats;
    logic        out_err;

    logic        sat_in_ready;
    logic        sat_out_valid;
    logic [7:0]  sat_out_data;
    logic [1:0]  sat_out_beats;
    logic        sat_out_err;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    logic_reduce_pipe #(.WIDTH(8), .NUM_IN(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_beats (out_beats),
        .out_err   (out_err)
    );

    logic_reduce_pipe #(.WIDTH(8), .NUM_IN(4), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (sat_in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_last   (in_last),
        .out_valid (sat_out_valid),
        .out_ready (out_ready),
        .out_data  (sat_out_data),
        .out_beats (sat_out_beats),
        .out_err   (sat_out_err)
    );

    typedef struct {
        logic [31:0] data;
        logic [2:0]  op;
        logic [7:0]  exp_data;
        logic [7:0]  exp_beats;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [2:0] op, input logic last);
        int n;
        in_data  = d;
        in_op    = op;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            vec_cnt++;
            miss_cnt++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        chk("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic chk_out(input string name, input logic [7:0] d, input logic [7:0] b, input logic e);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_data"},  32'(out_data),  32'(d));
        chk({name, "_beats"}, 32'(out_beats), 32'(b));
        chk({name, "_err"},   32'(out_err),   32'(e));
    endtask

    vec_t vecs[6];

    initial begin
        // words 0xF0, 0xCC, 0xAA, 0xFF
        vecs[0] = '{32'hFFAACCF0, 3'd0, 8'h80, 8'd1, 1'b0};
        vecs[1] = '{32'hFFAACCF0, 3'd1, 8'hFF, 8'd1, 1'b0};
        vecs[2] = '{32'hFFAACCF0, 3'd2, 8'h69, 8'd1, 1'b0};
        vecs[3] = '{32'hFFAACCF0, 3'd3, 8'h7F, 8'd1, 1'b0};
        vecs[4] = '{32'hFFAACCF0, 3'd4, 8'h00, 8'd1, 1'b0};
        vecs[5] = '{32'hFFAACCF0, 3'd5, 8'h96, 8'd1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_beats", 32'(out_beats), 32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back single-beat packets, one per cycle
        for (int i = 0; i < 6; i++) begin
            in_data  = vecs[i].data;
            in_op    = vecs[i].op;
            in_last  = 1'b1;
            in_valid = 1'b1;
            #1;
            chk($sformatf("sweep%0d_in_ready", i), 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            chk_out($sformatf("sweep%0d", i), vecs[i].exp_data, vecs[i].exp_beats, vecs[i].exp_err);
        end
        in_valid = 1'b0;
        drain();

        // 3-beat NOR, op changed to AND on the second beat must be ignored
        send(32'h00000001, 3'd4, 1'b0);
        chk("nor_b1_no_out", 32'(out_valid), 32'd0);
        send(32'h00000002, 3'd0, 1'b0);
        chk("nor_b2_no_out", 32'(out_valid), 32'd0);
        send(32'h00000004, 3'd4, 1'b1);
        chk_out("nor3", 8'hF8, 8'd3, 1'b0);
        drain();

        // Backpressure with a second beat waiting
        out_ready = 1'b0;
        send(32'h00000011, 3'd1, 1'b1);
        chk_out("bp_first", 8'h11, 8'd1, 1'b0);
        in_data  = 32'h00000022;
        in_op    = 3'd1;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_stall%0d_in_ready", i), 32'(in_ready), 32'd0);
            chk($sformatf("bp_stall%0d_data", i), 32'(out_data), 32'h11);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk_out("bp_swap", 8'h22, 8'd1, 1'b0);
        drain();

        // Reserved op, 2 beats, then a normal OR packet
        send(32'h000000FF, 3'd6, 1'b0);
        send(32'h000000FF, 3'd0, 1'b1);
        chk_out("reserved", 8'h00, 8'd2, 1'b1);
        drain();
        send(32'h00000301, 3'd1, 1'b1);
        chk_out("after_reserved", 8'h03, 8'd1, 1'b0);
        drain();

        // Reset in the middle of an open XOR packet
        send(32'h00000001, 3'd2, 1'b0);
        send(32'h00000002, 3'd2, 1'b0);
        chk("open_no_out", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data",  32'(out_data),  32'd0);
        chk("mid_rst_beats", 32'(out_beats), 32'd0);
        chk("mid_rst_err",   32'(out_err),   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_mid_rst_valid", 32'(out_valid), 32'd0);
        send(32'h00010F0F, 3'd2, 1'b1);
        chk_out("xor_after_rst", 8'h01, 8'd1, 1'b0);
        drain();

        // 6-beat OR: full counter on the 8-bit instance, saturated on the 2-bit one
        chk("sat_in_ready", 32'(sat_in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            send(32'(1 << i), 3'd1, (i == 5));
        end
        chk_out("or6", 8'h3F, 8'd6, 1'b0);
        chk("sat_valid", 32'(sat_out_valid), 32'd1);
        chk("sat_data",  32'(sat_out_data),  32'h3F);
        chk("sat_beats", 32'(sat_out_beats), 32'd3);
        chk("sat_err",   32'(sat_out_err),   32'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
